// File: rtl/l2_ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_ahb_pkg
//  Description : Shared AHB encodings (HTRANS, HBURST) and burst-length
//                helper for the L2 AHB bus-matrix output-stage arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // Beats remaining after the NONSEQ of a fixed-length burst; undefined
    // length bursts (INCR) and singles carry no hold.
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        logic [3:0] beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
            default:                      beats = 4'd0;
        endcase
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_ahb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : l2_ahb_rr_pick
//  Description : Combinational rotate-priority picker. Scans ports starting
//                at last_port+1 and wrapping, so the last winner is checked
//                last.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_ahb_rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_port,
    output logic [PORT_W-1:0]    grant,
    output logic                 any_req
);

    logic [PORT_W-1:0] idx;

    // First requesting port found in cyclic order after the last winner
    always_comb begin
        grant   = last_port;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_W'((int'(last_port) + i) % NUM_PORTS);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/l2_ahb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : l2_ahb_rr_arb
//  Description : Round-robin arbiter for an L2 AHB bus-matrix output stage.
//                Grant is held across locked sequences and, when
//                L2AHB_ARB_BURST_HOLD_EN is defined, across fixed-length
//                bursts. Outputs are registered.
//  Config      : L2AHB_ARB_BURST_HOLD_EN - build the burst beat counter
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_ahb_rr_arb
    import l2_ahb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    logic [PORT_W-1:0] last_port;
    logic [PORT_W-1:0] pick_grant;
    logic              pick_any;
    logic              lock_hold;
    logic              burst_hold;
    logic              hold;

    l2_ahb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req       (req_port),
        .last_port (last_port),
        .grant     (pick_grant),
        .any_req   (pick_any)
    );

`ifdef L2AHB_ARB_BURST_HOLD_EN
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_nxt;

    // Next beat count: load on a selected NONSEQ, count accepted SEQ beats,
    // and drop to zero on early termination (IDLE, NONSEQ or deselect)
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (beat_cnt != 4'd0) begin
            if (!HSELM || (HTRANSM == HTRANS_IDLE) || (HTRANSM == HTRANS_NONSEQ))
                beat_cnt_nxt = 4'd0;
            else if (HTRANSM == HTRANS_SEQ)
                beat_cnt_nxt = beat_cnt - 4'd1;
        end else if (HSELM && (HTRANSM == HTRANS_NONSEQ)) begin
            beat_cnt_nxt = burst_beats_m1(HBURSTM);
        end
    end

    // Beat counter advances only on ready edges
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            beat_cnt <= 4'd0;
        else if (HREADYM)
            beat_cnt <= beat_cnt_nxt;
    end

    // Hold on the post-edge count: the accepted NONSEQ already pins the
    // grant, while the final SEQ or an early termination releases it on the
    // same edge.
    assign burst_hold = (beat_cnt_nxt != 4'd0);
`else
    logic unused_burst;
    assign unused_burst = ^{HBURSTM, HTRANSM[0]};
    assign burst_hold   = 1'b0;
`endif

    assign hold = HMASTLOCKM | lock_hold | burst_hold;

    // Sticky lock bridges locked sequences that briefly deselect the slave
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            lock_hold <= 1'b0;
        else if (HREADYM) begin
            if (!HMASTLOCKM)
                lock_hold <= 1'b0;
            else if (HSELM && HTRANSM[1])
                lock_hold <= 1'b1;
        end
    end

    // Grant register: hold, re-arbitrate, or park with addr_in_port frozen
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            last_port    <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            if (hold) begin
                no_port <= 1'b0;
            end else if (pick_any) begin
                addr_in_port <= pick_grant;
                last_port    <= pick_grant;
                no_port      <= 1'b0;
            end else begin
                no_port <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // Granted index must always name an existing port
    always @(posedge HCLK) begin
        if (HRESETn)
            assert (int'(addr_in_port) < NUM_PORTS);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_ahb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_ahb_rr_arb
//  Description : Directed self-checking bench for l2_ahb_rr_arb with an
//                expected-grant queue. Burst expectations follow
//                L2AHB_ARB_BURST_HOLD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_ahb_rr_arb;
    import l2_ahb_pkg::*;

    logic       HCLK;
    logic       HRESETn;
    logic [2:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;
    logic [1:0] addr_in_port;
    logic       no_port;

    typedef struct {
        string      tag;
        logic [1:0] port;
        logic       none;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    l2_ahb_rr_arb #(
        .NUM_PORTS (3),
        .PORT_W    (2)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string tag, input logic [1:0] port, input logic none);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.none = none;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        tests_run++;
        assert (addr_in_port === e.port) else begin
            tests_failed++;
            $error("FAIL %s.addr_in_port: observed %0d expected %0d", e.tag, addr_in_port, e.port);
        end
        tests_run++;
        assert (no_port === e.none) else begin
            tests_failed++;
            $error("FAIL %s.no_port: observed %0b expected %0b", e.tag, no_port, e.none);
        end
    endtask

    // One clock: drive inputs, queue expected registered result, check after edge
    task automatic cyc(input string tag, input logic [2:0] rq, input logic rdy,
                       input logic sl, input logic [1:0] tr, input logic [2:0] bu,
                       input logic lk, input logic [1:0] ep, input logic en);
        req_port   = rq;
        HREADYM    = rdy;
        HSELM      = sl;
        HTRANSM    = tr;
        HBURSTM    = bu;
        HMASTLOCKM = lk;
        push_exp(tag, ep, en);
        @(posedge HCLK);
        #1;
        pop_check();
    endtask

    // Asynchronous reset pulse: outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        HRESETn = 1'b0;
        #1;
        push_exp({tag, "_async"}, 2'd0, 1'b1);
        pop_check();
        @(posedge HCLK);
        #1;
        push_exp({tag, "_held"}, 2'd0, 1'b1);
        pop_check();
        HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn    = 1'b0;
        req_port   = '0;
        HREADYM    = 1'b1;
        HSELM      = 1'b0;
        HTRANSM    = HTRANS_IDLE;
        HBURSTM    = HBURST_SINGLE;
        HMASTLOCKM = 1'b0;
        @(posedge HCLK);
        #1;
        do_reset("reset");

        // First grant from reset: pointer at port 2, so port 1 wins over 2
        cyc("first_grant", 3'b110, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd1, 0);

        // Fairness with all ports requesting single transfers
        do_reset("reset2");
        cyc("rr0", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("rr1", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd1, 0);
        cyc("rr2", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd2, 0);
        cyc("rr3", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("rr4", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd1, 0);
        cyc("rr5", 3'b111, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'd2, 0);

        // Locked sequence on port 1, including a deselected cycle
        cyc("lk_grant", 3'b010, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd1, 0);
        cyc("lk_t0",    3'b110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 2'd1, 0);
        cyc("lk_t1",    3'b110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 2'd1, 0);
        cyc("lk_desel", 3'b110, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 1, 2'd1, 0);
        cyc("lk_t3",    3'b110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 2'd1, 0);
        // Lock drops: the sticky lock still covers this edge and clears on it
        cyc("lk_rel",   3'b100, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd1, 0);
        cyc("lk_next",  3'b100, 1, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd2, 0);

        // Wait states freeze the grant; first ready edge arbitrates
        cyc("ws_grant", 3'b001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("ws0",      3'b100, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("ws1",      3'b100, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("ws2",      3'b100, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
        cyc("ws_ready", 3'b100, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd2, 0);

        // No requests: park with the last index kept
        cyc("park", 3'b000, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd2, 1);

        // INCR4 on port 0 with port 1 waiting
        cyc("b_grant", 3'b001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'd0, 0);
`ifdef L2AHB_ARB_BURST_HOLD_EN
        cyc("b_nseq",  3'b011, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_seq1",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_busy",  3'b011, 1, 1, HTRANS_BUSY,   HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_seq2",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_seq3",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd1, 0);
`else
        cyc("b_nseq",  3'b011, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0, 2'd1, 0);
        cyc("b_seq1",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_busy",  3'b011, 1, 1, HTRANS_BUSY,   HBURST_INCR4, 0, 2'd1, 0);
        cyc("b_seq2",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd0, 0);
        cyc("b_seq3",  3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR4, 0, 2'd1, 0);
`endif

        // Locked INCR8 on port 0 interrupted by reset
        cyc("r_grant", 3'b001, 1, 0, HTRANS_IDLE,   HBURST_SINGLE, 0, 2'd0, 0);
        cyc("r_nseq",  3'b011, 1, 1, HTRANS_NONSEQ, HBURST_INCR8,  1, 2'd0, 0);
        cyc("r_seq",   3'b011, 1, 1, HTRANS_SEQ,    HBURST_INCR8,  1, 2'd0, 0);
        do_reset("mid_burst_rst");
        // Leftover burst or lock state would pin port 0 here
        cyc("r_after", 3'b010, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 2'd1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
